// File: rtl/vec_pkg.sv
// Shared constants and FSM encoding for the vector multiply-accumulate sequencer.
package vec_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam logic [31:0] ADDR_STEP = 32'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StRun   = ST_RUN,
    StDrain = ST_DRAIN,
    StFin   = ST_FIN
  } state_e;

endpackage

// File: rtl/vec_mul_stage.sv
// Registered multiply stage: one product per cycle, feeding the RAM accumulate port.
module vec_mul_stage
  import vec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [DATA_W-1:0] rv_a,
  input  logic [DATA_W-1:0] rv_b,
  output logic [DATA_W-1:0] wd,
  output logic              we
);

  logic [DATA_W-1:0] prod;
  logic [DATA_W-1:0] wd_q;
  logic              we_q;

  // Low half of the product; identical for signed and unsigned operands.
  assign prod = rv_a * rv_b;

  // Capture the product and its write strobe; reset drops the strobe at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
      we_q <= 1'b0;
    end else begin
      we_q <= valid;
      if (valid) wd_q <= prod;
    end
  end

  assign wd = wd_q;
  assign we = we_q;

endmodule

// File: rtl/vec_mac_seq.sv
// Vector MAC sequencer: walks A and B through the RAM read ports and issues one
// accumulate-write per element on port c. Optional macro VMAC_REDUCE_EN adds a
// `reduce` input that pins addr_c to base_c so C[0] collects the dot product.
module vec_mac_seq
  import vec_pkg::*;
#(
  parameter int unsigned LEN_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       base_a,
  input  logic [31:0]       base_b,
  input  logic [31:0]       base_c,
  input  logic [LEN_W-1:0]  len,
`ifdef VMAC_REDUCE_EN
  input  logic              reduce,
`endif
  output logic              busy,
  output logic              done,
  output logic [31:0]       addr_a,
  output logic [31:0]       addr_b,
  input  logic [DATA_W-1:0] rv_a,
  input  logic [DATA_W-1:0] rv_b,
  output logic [31:0]       addr_c,
  output logic [DATA_W-1:0] wd,
  output logic              we
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      addr_a_q, addr_a_d;
  logic [31:0]      addr_b_q, addr_b_d;
  logic [31:0]      addr_c_q, addr_c_d;
  logic [31:0]      cptr_q, cptr_d;
  logic             accept;
  logic             last;
  logic             reduce_q;

  assign accept = (state_q == StIdle) && start;
  assign last   = (cnt_q == len_q - LEN_W'(1));

`ifdef VMAC_REDUCE_EN
  // Latch the reduce mode together with the other operation parameters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reduce_q <= 1'b0;
    else if (accept) reduce_q <= reduce;
  end
`else
  assign reduce_q = 1'b0;
`endif

  // Next-state logic. A zero-length op still spends one busy cycle (in DRAIN)
  // so done lands one edge after start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (len == '0) ? StDrain : StRun;
      StRun:   if (last) state_d = StDrain;
      StDrain: state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Address and counter next-state; addr_c trails the read address by one element.
  always_comb begin
    cnt_d    = cnt_q;
    len_d    = len_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    addr_c_d = addr_c_q;
    cptr_d   = cptr_q;
    if (accept) begin
      cnt_d    = '0;
      len_d    = len;
      addr_a_d = base_a;
      addr_b_d = base_b;
      cptr_d   = base_c;
    end else if (state_q == StRun) begin
      addr_c_d = cptr_q;
      if (!reduce_q) cptr_d = cptr_q + ADDR_STEP;
      if (!last) begin
        cnt_d    = cnt_q + LEN_W'(1);
        addr_a_d = addr_a_q + ADDR_STEP;
        addr_b_d = addr_b_q + ADDR_STEP;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      len_q    <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_c_q <= '0;
      cptr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      addr_c_q <= addr_c_d;
      cptr_q   <= cptr_d;
    end
  end

  vec_mul_stage u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (state_q == StRun),
    .rv_a  (rv_a),
    .rv_b  (rv_b),
    .wd    (wd),
    .we    (we)
  );

  assign busy   = (state_q == StRun) || (state_q == StDrain);
  assign done   = (state_q == StFin);
  assign addr_a = addr_a_q;
  assign addr_b = addr_b_q;
  assign addr_c = addr_c_q;

endmodule

// File: tb/tb_vec_mac_seq.sv
// Bench for vec_mac_seq: behavioural RAM, reference model and write scoreboard.
module tb_vec_mac_seq;

  localparam int unsigned LEN_W = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [31:0]      base_a, base_b, base_c;
  logic [LEN_W-1:0] len;
`ifdef VMAC_REDUCE_EN
  logic             reduce;
`endif
  logic             busy, done, we;
  logic [31:0]      addr_a, addr_b, addr_c, rv_a, rv_b, wd;

  vec_mac_seq #(.LEN_W(LEN_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .base_a (base_a),
    .base_b (base_b),
    .base_c (base_c),
    .len    (len),
`ifdef VMAC_REDUCE_EN
    .reduce (reduce),
`endif
    .busy   (busy),
    .done   (done),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .rv_a   (rv_a),
    .rv_b   (rv_b),
    .addr_c (addr_c),
    .wd     (wd),
    .we     (we)
  );

  always #5 clk = ~clk;

  // 1024-word RAM: combinational reads, accumulate on write.
  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  assign rv_a = mem[addr_a[11:2]];
  assign rv_b = mem[addr_b[11:2]];

  always @(posedge clk) begin
    if (we === 1'b1) mem[addr_c[11:2]] = mem[addr_c[11:2]] + wd;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accumulate-write must match the next expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL write_unexpected: got addr %0h data %0h expected no write", addr_c, wd);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr_data", {addr_c, wd}, {mon_e.addr, mon_e.data});
      end
    end
  end

  task automatic poke(input int idx, input logic [31:0] v);
    mem[idx]     = v;
    ref_mem[idx] = v;
  endtask

  task automatic chk_mem(input string name);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s: %0d words differ, word %0d got %0h expected %0h",
               name, bad, first, mem[first], ref_mem[first]);
    end
  endtask

  // Reference: C[i] += A[i]*B[i] (or C[0] += sum in reduce mode), mod 2**32.
  task automatic ref_op(input logic [31:0] ba, input logic [31:0] bb, input logic [31:0] bc,
                        input int n, input bit red);
    logic [31:0] aa, ab, ac, p;
    for (int i = 0; i < n; i++) begin
      aa = ba + 32'(4 * i);
      ab = bb + 32'(4 * i);
      ac = red ? bc : bc + 32'(4 * i);
      p  = ref_mem[aa[11:2]] * ref_mem[ab[11:2]];
      exp_q.push_back('{addr: ac, data: p});
      ref_mem[ac[11:2]] = ref_mem[ac[11:2]] + p;
    end
  endtask

  task automatic run_op(input logic [31:0] ba, input logic [31:0] bb, input logic [31:0] bc,
                        input int n, input bit red, input bit restart);
    logic eb, ed, ew;
    ref_op(ba, bb, bc, n, red);
    @(negedge clk);
    base_a = ba;
    base_b = bb;
    base_c = bc;
    len    = LEN_W'(n);
`ifdef VMAC_REDUCE_EN
    reduce = red;
`endif
    start  = 1'b1;
    for (int k = 0; k <= n + 2; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (restart && k == 2) begin
        start  = 1'b1;
        base_a = 32'hDEAD_0000;
        len    = LEN_W'(3);
      end
      if (restart && k == 3) start = 1'b0;
      eb = (n == 0) ? (k == 0) : (k <= n);
      ed = (k == n + 1);
      ew = (n > 0) && (k >= 1) && (k <= n);
      chk($sformatf("busy_done_we_n%0d_k%0d", n, k), {busy, done, we}, {eb, ed, ew});
    end
    chk("queue_drained", exp_q.size(), 0);
    chk_mem("mem_after_op");
  endtask

  initial begin
    logic [31:0] ra, rb, rc;
    int          rn;
    bit          rr;
    rst_n  = 1'b0;
    start  = 1'b0;
    base_a = '0;
    base_b = '0;
    base_c = '0;
    len    = '0;
`ifdef VMAC_REDUCE_EN
    reduce = 1'b0;
`endif
    for (int i = 0; i < 1024; i++) poke(i, $urandom);
    #12;
    chk("reset_state", {busy, done, we, addr_a, addr_b, addr_c, wd}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Element-wise MAC on small known vectors.
    for (int i = 0; i < 4; i++) begin
      poke(i, 32'(i + 1));
      poke(256 + i, 32'(i + 5));
      poke(512 + i, 32'd10);
    end
    run_op(32'd0, 32'd1024, 32'd2048, 4, 1'b0, 1'b0);
    chk("c0", mem[512], 32'd15);
    chk("c1", mem[513], 32'd22);
    chk("c2", mem[514], 32'd31);
    chk("c3", mem[515], 32'd42);

    // Zero-length operation.
    run_op(32'd0, 32'd1024, 32'd2048, 0, 1'b0, 1'b0);

    // Product truncation.
    poke(100, 32'hFFFF_FFFF);
    poke(356, 32'd2);
    poke(700, 32'd1);
    run_op(32'd400, 32'd1424, 32'd2800, 1, 1'b0, 1'b0);
    chk("trunc_c", mem[700], 32'hFFFF_FFFF);

    // Second start while busy, with different bases and length, is ignored.
    run_op(32'd80, 32'd1200, 32'd2400, 6, 1'b0, 1'b1);

    // Reset after E2 of an 8-element op: only element 0 commits.
    ref_op(32'd160, 32'd1280, 32'd3200, 1, 1'b0);
    @(negedge clk);
    base_a = 32'd160;
    base_b = 32'd1280;
    base_c = 32'd3200;
    len    = LEN_W'(8);
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("reset_midop", {busy, done, we, addr_a, addr_b, addr_c, wd}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_queue", exp_q.size(), 0);
    chk_mem("mem_after_reset");
    run_op(32'd160, 32'd1280, 32'd3200, 8, 1'b0, 1'b0);

    // Address wrap with misaligned low bits passed through.
    run_op(32'd161, 32'd1202, 32'hFFFF_FFFB, 4, 1'b0, 1'b0);

`ifdef VMAC_REDUCE_EN
    // Dot product into C[0].
    for (int i = 0; i < 3; i++) begin
      poke(10 + i, 32'(i + 1));
      poke(266 + i, 32'(i + 4));
    end
    poke(520, 32'd0);
    run_op(32'd40, 32'd1064, 32'd2080, 3, 1'b1, 1'b0);
    chk("dot_c0", mem[520], 32'd32);
`endif

    // Randomised operations over disjoint A/B/C regions.
    for (int t = 0; t < 20; t++) begin
      rn = $urandom_range(0, 40);
      ra = 32'(4 * $urandom_range(0, 200)) | 32'($urandom_range(0, 3));
      rb = 32'(4 * (256 + $urandom_range(0, 200))) | 32'($urandom_range(0, 3));
      rc = 32'(4 * (512 + $urandom_range(0, 400))) | 32'($urandom_range(0, 3));
`ifdef VMAC_REDUCE_EN
      rr = 1'($urandom_range(0, 1));
`else
      rr = 1'b0;
`endif
      run_op(ra, rb, rc, rn, rr, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
